// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
// Pulled into each clock domain's reset controller.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..v, never less than one.
  function automatic int clog2_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/rst_sync_ff.sv
// Reset synchronizer: asserts asynchronously with rst_n and releases
// synchronously after SYNC_STAGES clock edges.
module rst_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: one board reset fans out to NUM_STAGES per-block
// resets that assert together and release one by one, STAGE_DLY apart.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 8,
  parameter int STAGE_DLY   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done
);

  localparam int CNT_W = clog2_w(max2(HOLD_CYC, STAGE_DLY));
  localparam int IDX_W = clog2_w(NUM_STAGES);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  logic rst_sync_n;

  rst_sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  seq_state_t            state_q, state_d;
  logic                  armed_q, armed_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  sw_req_p0;
  logic                  sw_rise;

  // Previous sample resets high so a request held through board reset is
  // not mistaken for a new edge.
  assign sw_rise = sw_rst_req & ~sw_req_p0;

  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;

    if (sw_rise) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else if (!armed_q) begin
      // First edge with the synchronized reset released: hold starts here.
      state_d = S_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            idx_d   = IDX_W'(1);
            stage_d = NUM_STAGES'(1);
            if (NUM_STAGES == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_REL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REL: begin
          if (cnt_q == DLY_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            stage_d = (stage_q << 1) | NUM_STAGES'(1);
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= S_HOLD;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      stage_q   <= '0;
      done_q    <= 1'b0;
      sw_req_p0 <= 1'b1;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      done_q    <= done_d;
      sw_req_p0 <= sw_rst_req;
    end
  end

  assign stage_rst_n = stage_q;
  assign seq_done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-stage instance plus a
// minimal single-stage instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] stage_rst_n;
  logic       seq_done;

  logic       rst1_n = 1'b0;
  logic       sw1 = 1'b0;
  logic [0:0] stage1;
  logic       done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_rst_req  (sw_rst_req),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done)
  );

  reset_sequencer #(
    .NUM_STAGES  (1),
    .SYNC_STAGES (2),
    .HOLD_CYC    (1),
    .STAGE_DLY   (1)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst1_n),
    .sw_rst_req  (sw1),
    .stage_rst_n (stage1),
    .seq_done    (done1)
  );

  // Expected pattern n edges after the stage-0 release edge (n<0: before it).
  function automatic logic [3:0] exp_therm(input int n);
    int rel;
    if (n < 0) rel = 0;
    else rel = n / 16 + 1;
    if (rel > 4) rel = 4;
    return 4'((1 << rel) - 1);
  endfunction

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state stage=%b done=%b exp stage=0000 done=0", stage_rst_n, seq_done);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 62; e++) begin
      @(posedge clk); #1;
      checks++;
      if (stage_rst_n !== exp_therm(e - 11) || seq_done !== (e >= 59)) begin
        errors++;
        $display("FAIL power_on edge %0d stage=%b done=%b exp stage=%b done=%b",
                 e, stage_rst_n, seq_done, exp_therm(e - 11), (e >= 59));
      end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL async_assert stage=%b done=%b exp stage=0000 done=0", stage_rst_n, seq_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 62; e++) begin
      @(posedge clk); #1;
      checks++;
      if (stage_rst_n !== exp_therm(e - 11) || seq_done !== (e >= 59)) begin
        errors++;
        $display("FAIL async_restart edge %0d stage=%b done=%b exp stage=%b done=%b",
                 e, stage_rst_n, seq_done, exp_therm(e - 11), (e >= 59));
      end
    end
  endtask

  task automatic test_soft_run();
    @(negedge clk) sw_rst_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL soft_assert stage=%b done=%b exp stage=0000 done=0", stage_rst_n, seq_done);
    end
    @(negedge clk) sw_rst_req = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      checks++;
      if (stage_rst_n !== exp_therm(i - 8) || seq_done !== (i >= 56)) begin
        errors++;
        $display("FAIL soft_run E+%0d stage=%b done=%b exp stage=%b done=%b",
                 i, stage_rst_n, seq_done, exp_therm(i - 8), (i >= 56));
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk) sw_rst_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if (stage_rst_n !== exp_therm(i - 8) || seq_done !== (i >= 56)) begin
        errors++;
        $display("FAIL level_hold E+%0d stage=%b done=%b exp stage=%b done=%b",
                 i, stage_rst_n, seq_done, exp_therm(i - 8), (i >= 56));
      end
    end
    @(negedge clk) sw_rst_req = 1'b0;
    @(negedge clk) sw_rst_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) sw_rst_req = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (stage_rst_n !== 4'b0011) begin
      errors++;
      $display("FAIL mid_rel_state stage=%b exp 0011", stage_rst_n);
    end
    @(negedge clk) sw_rst_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rel_reassert stage=%b done=%b exp stage=0000 done=0", stage_rst_n, seq_done);
    end
    @(negedge clk) sw_rst_req = 1'b0;
    for (int i = 1; i <= 58; i++) begin
      @(posedge clk); #1;
      checks++;
      if (stage_rst_n !== exp_therm(i - 8) || seq_done !== (i >= 56)) begin
        errors++;
        $display("FAIL mid_rel_restart E+%0d stage=%b done=%b exp stage=%b done=%b",
                 i, stage_rst_n, seq_done, exp_therm(i - 8), (i >= 56));
      end
    end
  endtask

  task automatic test_req_through_reset();
    @(negedge clk) begin
      rst_n = 1'b0;
      sw_rst_req = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 62; e++) begin
      @(posedge clk); #1;
      checks++;
      if (stage_rst_n !== exp_therm(e - 11) || seq_done !== (e >= 59)) begin
        errors++;
        $display("FAIL req_held_power_on edge %0d stage=%b done=%b exp stage=%b done=%b",
                 e, stage_rst_n, seq_done, exp_therm(e - 11), (e >= 59));
      end
    end
    @(negedge clk) sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stage_rst_n !== 4'b1111 || seq_done !== 1'b1) begin
      errors++;
      $display("FAIL req_drop stage=%b done=%b exp stage=1111 done=1", stage_rst_n, seq_done);
    end
  endtask

  task automatic test_single_stage();
    @(negedge clk) rst1_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      checks++;
      if (stage1 !== 1'(e >= 4) || done1 !== (e >= 4)) begin
        errors++;
        $display("FAIL single_power_on edge %0d stage=%b done=%b exp %b", e, stage1, done1, (e >= 4));
      end
    end
    @(negedge clk) sw1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (stage1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL single_soft_assert stage=%b done=%b exp 0", stage1, done1);
    end
    @(negedge clk) sw1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (stage1 !== 1'b1 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL single_soft_release stage=%b done=%b exp 1", stage1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_soft_run();
    test_back_to_back();
    test_req_through_reset();
    test_single_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset controller that turns one board-level asynchronous active-low reset into NUM_STAGES staged, per-block reset outputs. Every output asserts asynchronously, and outputs release synchronously in a fixed order with a programmable gap between stages. A synchronous software reset request re-runs the full assert/hold/release sequence without touching the board reset. Sits at the top of each clock domain and drives the rst_n inputs of that domain's datapath blocks: stage 0 first (e.g. clocking/config), the last stage last (e.g. output registers).

## Interface
- NUM_STAGES, 4: number of staged reset outputs; legal range 1..16.
- SYNC_STAGES, 2: flops in the reset-release synchronizer; minimum 2.
- HOLD_CYC, 8: cycles all outputs stay asserted after the synchronized release or a soft request, before stage 0 releases; minimum 1.
- STAGE_DLY, 16: cycles between release of stage k and stage k+1; minimum 1.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset; assertion is asynchronous, deassertion passes through the synchronizer.
- sw_rst_req  in  1  synchronous to clk; a rising edge (sampled high, previous sample low) requests a soft reset sequence.
- stage_rst_n  out  NUM_STAGES  per-stage active-low resets; bit 0 releases first.
- seq_done  out  1  high while all stages are released.

## Operation
- Synchronizer: rst_sync_n is cleared asynchronously by rst_n low and shifts in 1 through SYNC_STAGES flops. All FSM, counter and output flops use rst_sync_n as their asynchronous clear.
- FSM states:
  - S_HOLD: entered from reset at the first edge where rst_sync_n is high. All outputs low. Counter counts HOLD_CYC cycles, then stage 0 releases, idx=1, and the FSM goes to S_REL. If NUM_STAGES=1, it goes to S_RUN instead.
  - S_REL: counter counts STAGE_DLY cycles, then stage idx releases and idx increments. When the last stage releases, the FSM goes to S_RUN.
  - S_RUN: idle; seq_done=1.
- Released stages stay high (thermometer pattern: stage_rst_n = 2^idx − 1 during S_REL).
- Soft reset: a sw_rst_req rising edge in any state forces all stage_rst_n=0 and seq_done=0 at that edge, clears the counter and idx, and enters S_HOLD. This includes a request mid-HOLD (restarts hold) and mid-REL (re-asserts stages already released).
- Level-high sw_rst_req does not retrigger; only the 0→1 transition counts. The edge-detect register resets to 1, so a request held high through board reset is ignored until it drops and rises again.
- rst_n low at any time: all outputs go to 0 asynchronously, independent of clk, and the full sequence restarts after release.
- Counter width: clog2(max(HOLD_CYC, STAGE_DLY)+1); no wrap in legal use.
- Reset values: stage_rst_n=0, seq_done=0, state=S_HOLD-pending (waits on rst_sync_n), counter=0, idx=0.

## Timing
- Edge numbering: edge 1 is the first rising clk edge after rst_n deasserts.
- rst_sync_n goes high after edge SYNC_STAGES. The FSM enters S_HOLD at edge SYNC_STAGES+1.
- stage_rst_n[k] rises after edge SYNC_STAGES+1+HOLD_CYC+k·STAGE_DLY. With defaults that is edges 11, 27, 43, 59.
- seq_done rises on the same edge as the last stage's release.
- Soft request detected at edge E: all outputs low after E, stage k high after E+HOLD_CYC+k·STAGE_DLY.
- Outputs come straight from flops; there is no combinational path from any input to any output except the asynchronous clear.

## Structure
- Shared package rst_seq_pkg: state enum (S_HOLD, S_REL, S_RUN) and a clog2 width helper.
- Sub-module rst_sync_ff: a SYNC_STAGES-deep asynchronous-assert/synchronous-release synchronizer, reused by other domains.
- Top level holds the FSM, the delay counter, the stage index, the sw_rst_req edge detector and the output register.

## Test plan
- Power-on, defaults: rst_n low 5 cycles then high -> stage_rst_n 0000 until edge 11, then 0001@11, 0011@27, 0111@43, 1111@59; seq_done=1@59.
- rst_n pulsed low mid-cycle in S_RUN -> stage_rst_n=0000 and seq_done=0 immediately without a clock edge; the sequence repeats with the same offsets.
- sw_rst_req 0→1 at edge E in S_RUN -> 0000 after E, 0001 after E+8, 1111 after E+56.
- sw_rst_req held high 100 cycles -> exactly one sequence; a second rising edge during S_REL (stage_rst_n=0011) -> 0000 next edge, hold restarts.
- NUM_STAGES=1, HOLD_CYC=1, STAGE_DLY=1 -> stage_rst_n[0] and seq_done rise after edge 4.
- sw_rst_req high while rst_n low, then rst_n released with the request still high -> no extra sequence; the normal power-on timing is unchanged.
